// File: rtl/score_scan_ctrl_pkg.sv
// Shared types and constants for the score display sequencer:
// FSM encoding, BCD limits, blank code and a one-digit BCD adder.
package score_scan_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_D0   = 3'd1,
      ST_D1   = 3'd2,
      ST_D2   = 3'd3,
      ST_ACK  = 3'd4,
      ST_WAIT = 3'd5
   } state_t;

   localparam logic [3:0] BCD_MAX    = 4'd9;
   localparam logic [3:0] BLANK_CODE = 4'hF;
   localparam logic [1:0] STCL_LAST  = 2'd2;

   // Returns {carry, digit} for one BCD digit plus an addend of 0..9.
   function automatic logic [4:0] bcd_add(input logic [3:0] digit, input logic [3:0] addend);
      logic [4:0] s;
      s = {1'b0, digit} + {1'b0, addend};
      if (s >= 5'd10) return {1'b1, 4'(s - 5'd10)};
      return {1'b0, s[3:0]};
   endfunction

endpackage

// File: rtl/score_scan_ctrl_if.sv
// Score-add request channel between the game logic and the score sequencer.
// Four-phase handshake: the master raises add_req with add_val stable, the slave
// pulses add_ack once the sum is committed, and the master must drop add_req for
// at least one cycle before the next request is accepted.
interface score_scan_ctrl_if;
   logic       add_req;
   logic [3:0] add_val;
   logic       add_ack;
   logic       busy;

   modport master (output add_req, output add_val, input add_ack, input busy);
   modport slave  (input add_req, input add_val, output add_ack, output busy);
endinterface

// File: rtl/score_scan_ctrl_scan_divider.sv
// Free-running prescaler driving a 0,1,2 digit-scan select for multiplexed
// seven-segment displays.
module scan_divider
   import score_scan_ctrl_pkg::*;
#(
   parameter int SCAN_W = 17
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [1:0] stcl
);

   logic [SCAN_W-1:0] cnt_q;
   logic [1:0]        stcl_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         stcl_q <= 2'd0;
      end else begin
         cnt_q <= cnt_q + SCAN_W'(1);
         // The select steps on the cycle the prescaler wraps back to zero.
         if (&cnt_q) stcl_q <= (stcl_q == STCL_LAST) ? 2'd0 : stcl_q + 2'd1;
      end
   end

   assign stcl = stcl_q;

endmodule

// File: rtl/score_scan_ctrl.sv
// Three-digit BCD score keeper with a multi-cycle carry FSM, digit-scan select
// and leading-zero blanking for the seven-segment decoder.
module score_scan_ctrl
   import score_scan_ctrl_pkg::*;
#(
   parameter int SCAN_W   = 17,
   parameter int BLANK_LZ = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   score_scan_ctrl_if.slave   bus,
   output logic               sat,
   output logic [1:0]         stcl,
   output logic [3:0]         score0,
   output logic [3:0]         score1,
   output logic [3:0]         score2,
   output state_t             dbg_state
);

   state_t     state_q, state_n;
   logic [3:0] v_q, v_n;
   logic [3:0] w0_q, w1_q, w2_q, w0_n, w1_n, w2_n;
   logic [3:0] c0_q, c1_q, c2_q, c0_n, c1_n, c2_n;
   logic       carry_q, carry_n;
   logic       sat_q, sat_n;
   logic       ack_q, ack_n;
   logic [4:0] sum;

   scan_divider #(.SCAN_W(SCAN_W)) u_scan (
      .clk  (clk),
      .rst_n(rst_n),
      .stcl (stcl)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         v_q     <= 4'd0;
         w0_q    <= 4'd0;  w1_q <= 4'd0;  w2_q <= 4'd0;
         c0_q    <= 4'd0;  c1_q <= 4'd0;  c2_q <= 4'd0;
         carry_q <= 1'b0;
         sat_q   <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         v_q     <= v_n;
         w0_q    <= w0_n;  w1_q <= w1_n;  w2_q <= w2_n;
         c0_q    <= c0_n;  c1_q <= c1_n;  c2_q <= c2_n;
         carry_q <= carry_n;
         sat_q   <= sat_n;
         ack_q   <= ack_n;
      end
   end

   always_comb begin
      state_n = state_q;
      v_n     = v_q;
      w0_n    = w0_q;  w1_n = w1_q;  w2_n = w2_q;
      c0_n    = c0_q;  c1_n = c1_q;  c2_n = c2_q;
      carry_n = carry_q;
      sat_n   = sat_q;
      ack_n   = 1'b0;
      sum     = 5'd0;
      if (clr) begin
         // Aborts any add in flight; a held request parks in WAIT so it is not re-taken.
         w0_n = 4'd0;  w1_n = 4'd0;  w2_n = 4'd0;
         c0_n = 4'd0;  c1_n = 4'd0;  c2_n = 4'd0;
         carry_n = 1'b0;
         sat_n   = 1'b0;
         state_n = bus.add_req ? ST_WAIT : ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (bus.add_req) begin
               v_n  = (bus.add_val > BCD_MAX) ? BCD_MAX : bus.add_val;
               w0_n = c0_q;  w1_n = c1_q;  w2_n = c2_q;
               state_n = ST_D0;
            end
            ST_D0: begin
               sum = bcd_add(w0_q, v_q);
               w0_n = sum[3:0];  carry_n = sum[4];
               state_n = ST_D1;
            end
            ST_D1: begin
               sum = bcd_add(w1_q, {3'b000, carry_q});
               w1_n = sum[3:0];  carry_n = sum[4];
               state_n = ST_D2;
            end
            ST_D2: begin
               sum = bcd_add(w2_q, {3'b000, carry_q});
               // Hundreds overflow means the score passed 999: pin it there.
               if (sum[4]) begin
                  w0_n = BCD_MAX;  w1_n = BCD_MAX;  w2_n = BCD_MAX;
                  sat_n = 1'b1;
               end else begin
                  w2_n = sum[3:0];
               end
               state_n = ST_ACK;
            end
            ST_ACK: begin
               c0_n = w0_q;  c1_n = w1_q;  c2_n = w2_q;
               ack_n   = 1'b1;
               state_n = ST_WAIT;
            end
            ST_WAIT: if (!bus.add_req) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
         endcase
      end
   end

   assign bus.add_ack = ack_q;
   assign bus.busy    = (state_q != ST_IDLE);
   assign sat         = sat_q;
   assign dbg_state   = state_q;

   assign score0 = c0_q;
   assign score1 = ((BLANK_LZ != 0) && c2_q == 4'd0 && c1_q == 4'd0) ? BLANK_CODE : c1_q;
   assign score2 = ((BLANK_LZ != 0) && c2_q == 4'd0) ? BLANK_CODE : c2_q;

endmodule

// File: tb/tb_score_scan_ctrl.sv
// Directed bench for score_scan_ctrl: scan sequence, table of adds with
// hand-computed displays, carry ripple, saturation, hold, clear and reset abort.
module tb_score_scan_ctrl;
  import score_scan_ctrl_pkg::*;

  typedef struct {
    logic [3:0] val;
    logic [11:0] exp_disp;
    logic exp_sat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic sat;
  logic [1:0] stcl;
  logic [3:0] score0, score1, score2;
  state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int model_score = 0;
  logic model_sat = 1'b0;
  vec_t vecs[6];

  score_scan_ctrl_if bus();

  score_scan_ctrl #(.SCAN_W(2), .BLANK_LZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus), .sat(sat), .stcl(stcl),
    .score0(score0), .score1(score1), .score2(score2), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] disp(input int s);
    logic [3:0] d0, d1, d2, o1, o2;
    d0 = 4'(s % 10);
    d1 = 4'((s / 10) % 10);
    d2 = 4'(s / 100);
    o2 = (d2 == 4'd0) ? 4'hF : d2;
    o1 = (d2 == 4'd0 && d1 == 4'd0) ? 4'hF : d1;
    return {o2, o1, d0};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_add(input logic [3:0] val, input int hold);
    int n;
    int v;
    int nxt;
    logic [11:0] old_d;
    old_d = disp(model_score);
    v = (val > 4'd9) ? 9 : int'(val);
    nxt = model_score + v;
    if (nxt > 999) begin
      nxt = 999;
      model_sat = 1'b1;
    end
    bus.add_req = 1'b1;
    bus.add_val = val;
    n = 0;
    do begin
      tick();
      n++;
      if (!bus.add_ack) begin
        check("hold_display", {score2, score1, score0}, old_d);
        check("busy_in_add", bus.busy, 1'b1);
      end
    end while (!bus.add_ack && n < 20);
    check("ack_latency", n, 5);
    model_score = nxt;
    check("sum_display", {score2, score1, score0}, disp(nxt));
    check("sat", sat, model_sat);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("no_second_ack", bus.add_ack, 1'b0);
      check("busy_wait", bus.busy, 1'b1);
    end
    bus.add_req = 1'b0;
    tick();
    check("ack_one_cycle", bus.add_ack, 1'b0);
    check("idle_after_drop", bus.busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_score"}, {score2, score1, score0}, 12'hFF0);
    check({tag, "_sat"}, sat, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_ack"}, bus.add_ack, 1'b0);
    check({tag, "_stcl"}, stcl, 2'd0);
  endtask

  initial begin
    int m_cnt;
    logic [1:0] m_stcl;

    vecs[0] = '{val: 4'd7,  exp_disp: 12'hFF7, exp_sat: 1'b0};
    vecs[1] = '{val: 4'd5,  exp_disp: 12'hF12, exp_sat: 1'b0};
    vecs[2] = '{val: 4'd0,  exp_disp: 12'hF12, exp_sat: 1'b0};
    vecs[3] = '{val: 4'd12, exp_disp: 12'hF21, exp_sat: 1'b0};
    vecs[4] = '{val: 4'd15, exp_disp: 12'hF30, exp_sat: 1'b0};
    vecs[5] = '{val: 4'd9,  exp_disp: 12'hF39, exp_sat: 1'b0};

    bus.add_req = 1'b0;
    bus.add_val = 4'd0;

    // Reset state and scan sequence.
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    m_cnt = 0;
    m_stcl = 2'd0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (m_cnt == 3) m_stcl = (m_stcl == 2'd2) ? 2'd0 : m_stcl + 2'd1;
      m_cnt = (m_cnt + 1) % 4;
      check("stcl_seq", stcl, m_stcl);
    end

    // Table of adds from zero.
    foreach (vecs[i]) begin
      do_add(vecs[i].val, 0);
      check("vec_display", {score2, score1, score0}, vecs[i].exp_disp);
      check("vec_sat", sat, vecs[i].exp_sat);
    end

    // Clear while idle.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_score = 0;
    check("clr_idle", {score2, score1, score0}, 12'hFF0);

    // Carry ripple 099 + 1.
    for (int i = 0; i < 11; i++) do_add(4'd9, 0);
    check("at_099", {score2, score1, score0}, 12'hF99);
    do_add(4'd1, 0);
    check("ripple_100", {score2, score1, score0}, 12'h100);

    // Saturation.
    for (int i = 0; i < 99; i++) do_add(4'd9, 0);
    do_add(4'd4, 0);
    check("at_995", {score2, score1, score0}, 12'h995);
    check("sat_995", sat, 1'b0);
    do_add(4'd9, 0);
    check("sat_999", {score2, score1, score0}, 12'h999);
    check("sat_set", sat, 1'b1);
    do_add(4'd3, 0);
    check("sat_hold", {score2, score1, score0}, 12'h999);
    check("sat_sticky", sat, 1'b1);

    // Clear in D1 with the request held.
    bus.add_req = 1'b1;
    bus.add_val = 4'd3;
    tick();
    tick();
    check("state_d1", dbg_state, ST_D1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_score = 0;
    model_sat = 1'b0;
    check("clr_score", {score2, score1, score0}, 12'hFF0);
    check("clr_sat", sat, 1'b0);
    check("clr_state", dbg_state, ST_WAIT);
    for (int i = 0; i < 6; i++) begin
      check("clr_no_ack", bus.add_ack, 1'b0);
      check("clr_busy", bus.busy, 1'b1);
      tick();
    end
    bus.add_req = 1'b0;
    tick();
    check("clr_release", bus.busy, 1'b0);

    // Held request after ack, then re-request with a clamped value.
    do_add(4'd7, 5);
    check("hold_007", {score2, score1, score0}, 12'hFF7);
    do_add(4'd12, 0);
    check("clamp_016", {score2, score1, score0}, 12'hF16);

    // Reset pulsed mid-add.
    bus.add_req = 1'b1;
    bus.add_val = 4'd5;
    tick();
    tick();
    check("pre_rst_busy", bus.busy, 1'b1);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    bus.add_req = 1'b0;
    tick();
    rst_n = 1'b1;
    #1 check_reset_outputs("rst_release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_scan_ctrl.md
Name: score_scan_ctrl

Overview:
- Sequencer for the 3-digit seven-segment score display.
- Holds a 3-digit BCD score and adds to it through a four-phase req/ack handshake, using a multi-cycle carry state machine.
- Generates the digit-scan select (stcl) and the three per-digit codes that feed the seven-segment decoder; code 4'hF means blank digit.
- Sits between the game logic (score events) and the display decoder.

Parameters:
- SCAN_W, 17: scan prescaler width; stcl advances once every 2^SCAN_W clk cycles.
- BLANK_LZ, 1: 1 blanks leading zeros on score2/score1; 0 always shows all digits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous score clear (level, sampled each clk)
- add_req  in  1  add request, four-phase handshake
- add_val  in  4  amount to add, 0..9; values >9 are clamped to 9 at acceptance
- add_ack  out  1  one-cycle pulse when the add is committed
- busy  out  1  high in any state other than IDLE
- sat  out  1  sticky; set when the score saturated at 999
- stcl  out  2  digit scan select, sequence 0,1,2,0,...
- score0  out  4  ones-digit code for the decoder
- score1  out  4  tens-digit code, or 4'hF when blanked
- score2  out  4  hundreds-digit code, or 4'hF when blanked

Behaviour:
- Reset (async, rst_n=0):
  - Scan prescaler=0, stcl=0.
  - Committed digits c0..c2=0, working digits w0..w2=0.
  - State=IDLE, add_ack=0, sat=0.
  - Resulting outputs: score0=0; score1=score2=4'hF if BLANK_LZ, else 0.
- Scan:
  - SCAN_W-bit counter increments every clk, free-running, independent of clr and the FSM.
  - On wrap to 0, stcl advances 0->1->2->0. Value 3 is never produced.
- FSM states: IDLE, D0, D1, D2, ACK, WAIT.
  - IDLE: if add_req=1 -> D0. Latch v=min(add_val,9) and w0..w2=c0..c2.
  - D0: w0+=v. If the result is >=10, subtract 10 and set carry=1, else carry=0. -> D1.
  - D1: w1+=carry, same rule for the decimal wrap and carry. -> D2.
  - D2: w2+=carry. If w2 wraps (999 overflowed), set w0=w1=w2=9 and sat=1. -> ACK.
  - ACK: c0..c2<=w0..w2, add_ack=1 for exactly this cycle. -> WAIT.
  - WAIT: stay while add_req=1; -> IDLE when add_req=0.
  - Result: ack is issued 4 cycles after acceptance. Next acceptance requires add_req low for >=1 cycle after ack.
- Committed registers change only in ACK, so the display never shows a partial sum.
- sat=1 does not block adds: they handshake normally and the score stays 999.
- add_val=0 completes a full handshake and leaves the score unchanged.
- clr (priority over everything in the FSM):
  - c0..c2=w0..w2=0, sat=0, add_ack=0.
  - State -> WAIT if add_req=1, else IDLE.
  - Any in-flight add is aborted with no ack.
  - The requester must drop add_req and re-request.
- Output mapping:
  - score0=c0.
  - score1=4'hF if BLANK_LZ && c2==0 && c1==0, else c1.
  - score2=4'hF if BLANK_LZ && c2==0, else c2.
  - Outputs are combinational from registers.
- busy=(state!=IDLE). add_ack is registered.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE..WAIT, 3 bits).
  - Constants BCD_MAX=4'd9 and BLANK_CODE=4'hF.
  - STCL_LAST=2'd2.
- One natural sub-module: scan_divider (prescaler plus the stcl 0..2 counter, parameter SCAN_W), reusable for other scanned displays.
- BCD add and carry stays inline in the FSM.

Test Plan:
1. Reset with SCAN_W=2 -> stcl=0 and score0=0, score1=score2=F. Then stcl steps 0,1,2,0 every 4 clks, never 3.
2. From 0, add_req with add_val=7 -> add_ack pulses 4 clks after acceptance with score0=7, score1=score2=F. Then add 5 -> score0=2, score1=1, score2=F.
3. Set score 099, add 1 -> carry ripples: 1,0,0. Scores stay 0,9,9 (score2=F) until the ACK cycle.
4. Score 995, add 9 -> score=999, sat=1. A further add of 3 -> ack received, 999 unchanged, sat stays 1.
5. Hold add_req high after ack -> no second ack. Drop for 1 clk and raise again -> new add accepted. add_val=12 -> clamped, adds 9.
6. Assert clr in D1 with add_req high -> no ack, score 0, sat=0, busy stays high in WAIT until add_req drops. Repeat with rst_n pulsed mid-add -> all outputs at their reset values immediately.
